// File: rtl/shift_right_unit_pkg.sv
// Shared constants and state encoding for the iterative right-shift unit.
package shift_right_unit_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int STAGES  = 5;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_unit_sr_stage.sv
// One barrel-shifter stage: shift by 16>>sel when enabled, filling vacated bits with fill.
module sr_stage
  import shift_right_unit_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic [CNT_W-1:0]  sel,
  input  logic              en,
  input  logic              fill,
  output logic [DATA_W-1:0] shifted
);

  logic [SHAMT_W-1:0]      amount;
  logic signed [DATA_W:0]  ext;

  // Prepending the fill bit and shifting arithmetically replicates it into the vacated bits.
  always_comb begin
    amount  = 5'd16 >> sel;
    ext     = $signed({fill, value});
    shifted = en ? DATA_W'(ext >>> amount) : value;
  end

endmodule

// File: rtl/shift_right_unit.sv
// Multi-cycle right shifter: five fixed stages (16,8,4,2,1), one per clock, fixed latency.
module shift_right_unit
  import shift_right_unit_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   data_in,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic                arith,
  output logic [DATA_W-1:0]   result,
  output logic                ready,
  output logic                done
);

  state_t              state, state_next;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   work;
  logic [SHAMT_W-1:0]  amount;
  logic                mode;
  logic [CNT_W-1:0]    bit_idx;
  logic                stage_en;
  logic                fill;
  logic [DATA_W-1:0]   stage_out;

  // Stage k consumes shamt bit (4-k), so the largest shift is applied first.
  assign bit_idx  = CNT_W'(STAGES - 1) - count;
  assign stage_en = amount[bit_idx];
  assign fill     = mode & work[DATA_W-1];

  sr_stage u_stage (
    .value   (work),
    .sel     (count),
    .en      (stage_en),
    .fill    (fill),
    .shifted (stage_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      work   <= '0;
      amount <= '0;
      mode   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            work   <= data_in;
            amount <= shamt;
            mode   <= arith;
            count  <= '0;
          end
        end
        SHIFT: begin
          work  <= stage_out;
          count <= count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        if (count == CNT_W'(STAGES - 1)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign result = work;

endmodule

// File: tb/tb_shift_right_unit.sv
// Directed self-checking bench for shift_right_unit.
module tb_shift_right_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic [31:0] result;
  logic        ready;
  logic        done;

  int checks;
  int errors;

  shift_right_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .arith   (arith),
    .result  (result),
    .ready   (ready),
    .done    (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accepts one op from IDLE and follows it to done (bounded).
  task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                       output logic [31:0] res, output int lat,
                       output logic ready_low, output logic post_ok);
    data_in = d; shamt = s; arith = a; start = 1'b1;
    step();
    start = 1'b0;
    data_in = ~d; shamt = ~s; arith = ~a;
    lat = -1; res = 32'h0; ready_low = 1'b1; post_ok = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (ready) ready_low = 1'b0;
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      step();
    end
    step();
    post_ok = (done == 1'b0) && (ready == 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_in = 32'hDEADBEEF; shamt = 5'd3; arith = 1'b1;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%b done=%b result=%h, required ready=1 done=0 result=00000000",
               ready, done, result);
    end
  endtask

  task automatic test_shift(input string name, input logic [31:0] d, input logic [4:0] s,
                            input logic a, input logic [31:0] exp);
    logic [31:0] res;
    int          lat;
    logic        rl, po;
    do_op(d, s, a, res, lat, rl, po);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL %s_result: got %h, required %h", name, res, exp);
    end
    checks++;
    if (lat !== 6) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required 6", name, lat);
    end
    checks++;
    if (rl !== 1'b1 || po !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: ready_low=%b after_done_idle=%b, required 1 1", name, rl, po);
    end
  endtask

  task automatic test_ignore_start();
    int          n_done = 0;
    logic [31:0] res = 32'h0;
    data_in = 32'hA5A5A5A5; shamt = 5'd5; arith = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 2) begin
        start = 1'b1; data_in = 32'hFFFFFFFF; shamt = 5'd0; arith = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        res = result;
      end
      step();
    end
    checks++;
    if (res !== 32'h052D2D2D) begin
      errors++;
      $display("FAIL ignore_result: got %h, required 052d2d2d", res);
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_abort();
    int n_done = 0;
    data_in = 32'h12345678; shamt = 5'd8; arith = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || result !== 32'h0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: ready=%b done=%b result=%h, required 1 0 00000000",
               ready, done, result);
    end
    for (int c = 0; c < 10; c++) begin
      if (done) n_done++;
      step();
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_done_count: got %0d, required 0", n_done);
    end
    test_shift("after_abort", 32'h0000FF00, 5'd4, 1'b0, 32'h00000FF0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d_tab [3] = '{32'h12345678, 32'h80000000, 32'h7FFFFFFF};
    logic [4:0]  s_tab [3] = '{5'd8, 5'd31, 5'd3};
    logic        a_tab [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] e_tab [3] = '{32'h00123456, 32'hFFFFFFFF, 32'h0FFFFFFF};
    int          acc_t [3];
    int          n_acc = 0;
    int          n_done = 0;
    start = 1'b1;
    for (int c = 0; c < 40 && n_done < 3; c++) begin
      if (done) begin
        checks++;
        if (result !== e_tab[n_done]) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h, required %h", n_done, result, e_tab[n_done]);
        end
        n_done++;
        if (n_done == 3) start = 1'b0;
      end
      if (ready && n_acc < 3) begin
        data_in = d_tab[n_acc]; shamt = s_tab[n_acc]; arith = a_tab[n_acc];
        acc_t[n_acc] = c;
        n_acc++;
      end else begin
        data_in = 32'h5A5A0000 + 32'(c); shamt = 5'(c); arith = c[0];
      end
      if (n_done < 3) step();
    end
    start = 1'b0;
    checks++;
    if (n_done !== 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 3", n_done);
    end
    checks++;
    if (n_acc !== 3 || acc_t[1] - acc_t[0] !== 7 || acc_t[2] - acc_t[1] !== 7) begin
      errors++;
      $display("FAIL b2b_spacing: accepts=%0d gaps=%0d,%0d, required 3 accepts gaps 7,7",
               n_acc, acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
    end
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0; start = 1'b0; data_in = 32'h0; shamt = 5'd0; arith = 1'b0;
    test_reset();
    test_shift("basic",      32'h12345678, 5'd8,  1'b0, 32'h00123456);
    test_shift("sign31",     32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF);
    test_shift("logic31",    32'h80000000, 5'd31, 1'b0, 32'h00000001);
    test_shift("zero_shamt", 32'hF0F0F0F0, 5'd0,  1'b1, 32'hF0F0F0F0);
    test_shift("arith4",     32'h80000000, 5'd4,  1'b1, 32'hF8000000);
    test_shift("logic16",    32'hDEADBEEF, 5'd16, 1'b0, 32'h0000DEAD);
    test_shift("arith1",     32'h80000000, 5'd1,  1'b1, 32'hC0000000);
    test_shift("pos_arith",  32'h7FFFFFFF, 5'd30, 1'b1, 32'h00000001);
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, declared as: clock  in  1  rising-edge system clock.
REQ-002 The reset port SHALL be declared as: reset  in  1  synchronous, active-high reset.
REQ-003 start  in  1  request to begin a shift; accepted only when ready=1.
REQ-004 data_in  in  32  operand; sampled on the accepting edge.
REQ-005 shamt  in  5  shift amount, 0..31; sampled on the accepting edge.
REQ-006 arith  in  1  1 = arithmetic right shift (sign fill), 0 = logical right shift (zero fill); sampled on the accepting edge.
REQ-007 result  out  32  shifted value; valid while done=1 and held until the next accept.
REQ-008 ready  out  1  high only in IDLE.
REQ-009 done  out  1  one-cycle pulse marking result valid.

Function
REQ-010 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-011 IDLE -> SHIFT SHALL occur on an edge with start=1.
- That edge captures data_in into the working register, shamt into the amount register and arith into the mode flag.
- The same edge clears the stage counter to 0.
REQ-012 Each edge in SHIFT SHALL process stage k = counter value, with stage amount 16>>k (16, 8, 4, 2, 1).
- If shamt bit (4-k) is set, the working register is right-shifted by the stage amount; otherwise it is unchanged.
- The counter then increments.
REQ-013 Vacated upper bits SHALL be filled with the captured bit 31 when arith=1, and with 0 when arith=0.
REQ-014 After the stage-4 edge, the FSM SHALL move SHIFT -> DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-016 Latency SHALL be fixed: done is high during the 6th cycle after the accepting edge (5 stage edges), independent of shamt, including shamt=0.
REQ-017 start SHALL be ignored in SHIFT and DONE.
- No queuing, no restart.
- Captured operands are unaffected by input changes after acceptance.
REQ-018 result SHALL be driven from the working register.
- It is stable from DONE until the next accepting edge.
- Intermediate values are visible during SHIFT but are not flagged valid.
REQ-019 Each right shift SHALL remain within 32 bits: bits shifted out of bit 0 are discarded, and no wrap-around occurs.
REQ-020 shamt=0 SHALL return data_in unchanged; shamt=31 with arith=1 SHALL return 32 copies of the sign bit.

Reset
REQ-021 On an edge with reset=1, the state SHALL become IDLE, and the counter, working register, amount register and mode flag SHALL clear to 0.
REQ-022 After reset, the outputs SHALL be ready=1, done=0 and result=0x00000000.
REQ-023 Reset SHALL take priority over start on the same edge.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation, with no done pulse.

Structure
REQ-025 A shared package SHALL hold:
- state encoding constants IDLE/SHIFT/DONE;
- the data width constant (32);
- the shift-amount width constant (5);
- the stage count constant (5).
REQ-026 One sub-module, sr_stage, SHALL be instantiated once.
- It is purely combinational: inputs value, amount select (counter), enable bit and fill bit; output is the shifted value.
- The FSM, counter and registers stay in shift_right_unit.

Verification
REQ-027 0x12345678, shamt=8, arith=0 -> result 0x00123456 with a done pulse 6 cycles after the accepting edge; ready low for those 6 cycles.
REQ-028 0x80000000, shamt=31: arith=1 -> 0xFFFFFFFF; arith=0 -> 0x00000001.
REQ-029 0xF0F0F0F0, shamt=0, arith=1 -> 0xF0F0F0F0 with the same 6-cycle latency.
REQ-030 start pulsed again 2 cycles after acceptance with different data -> ignored; first result correct, and exactly one done pulse.
REQ-031 reset asserted on the 3rd SHIFT edge -> no done pulse; next cycle ready=1 and result=0; a following op 0x0000FF00, shamt=4, arith=0 -> 0x00000FF0.
REQ-032 Back-to-back: start held high continuously -> ops accepted only in IDLE, one every 7 cycles, each with a correct result.
